pattern_dac_gen: RTL and testbench
==================================

Name: pattern_dac_gen

Overview:
Parametrised successor to the single-channel PWM pattern DAC driver. It serialises a programmable-length bit pattern onto a DAC, one pattern bit per N clock cycles, and emits a configurable number of bursts (or unlimited bursts) separated by an idle gap. It adds programmable high, low and idle DAC codes, explicit pattern length, start on rising edge only, and a graceful-versus-abort stop mode. It sits between the register or control logic and the AD974x-class DAC data bus.

Parameters:
PAT_WIDTH, 16, maximum pattern length in bits
DAC_WIDTH, 14, DAC code width
DUTY_W, 8, width of the per-bit cycle count
GAP_W, 16, width of the inter-burst gap count
CNT_W, 8, width of the burst count
RST_CODE, 2**(DAC_WIDTH-1)-1, dac_data value while in reset

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pwm_en  in  1  level enable; a rising edge starts, a falling edge requests stop
abort  in  1  stop mode, sampled on the falling edge: 1 = immediate stop, 0 = finish the current pattern
duty_num  in  DUTY_W  clock cycles per pattern bit; 0 is treated as 1
gap_num  in  GAP_W  idle cycles between bursts; 0 means back-to-back bursts
pulse_num  in  CNT_W  number of bursts; 0 means unlimited
pat  in  PAT_WIDTH  pattern, LSB sent first
pat_len  in  $clog2(PAT_WIDTH)  pattern length minus 1
level_hi  in  DAC_WIDTH  DAC code driven for a 1 bit
level_lo  in  DAC_WIDTH  DAC code driven for a 0 bit and during the gap
idle_code  in  DAC_WIDTH  DAC code driven when not busy
dac_data  out  DAC_WIDTH  registered DAC code
pwm_out  out  1  registered current pattern bit
busy  out  1  high from ACTIVE entry through the DONE cycle
done  out  1  one-cycle pulse in the DONE state

Behaviour:
- Reset values: state IDLE, pwm_out 0, busy 0, done 0, dac_data RST_CODE, all counters 0, stop_req 0.
- Edge detect: last_en is a register. rise = pwm_en & ~last_en; fall = ~pwm_en & last_en.
- IDLE: dac_data = idle_code. On rise, latch duty_num, gap_num, pulse_num, pat, pat_len, level_hi and level_lo into shadow registers. At the next edge: ACTIVE, pwm_out = pat[0], busy = 1.
- Start latency: first pattern bit is visible 1 clk after the rising edge is sampled.
- A pwm_en level held high after DONE does not restart; a new rising edge is required.
- ACTIVE: each bit is held for max(duty,1) cycles.
  - When bit_idx < pat_len, advance bit_idx and drive pat[bit_idx+1].
  - After the last bit, burst_cnt increments. If pulse_num != 0 and burst_cnt+1 == pulse_num, go to DONE with no trailing gap.
  - Otherwise go to GAP, or if gap_num == 0, restart at pat[0] directly.
- GAP: pwm_out = 0 for gap_num cycles, then ACTIVE with pat[0] and bit_idx = 0.
- DONE (1 cycle): done = 1, pwm_out = 0; then IDLE with busy = 0.
- Stop handling:
  - fall sets stop_req and latches abort into stop_abort. This applies in both finite and unlimited modes.
  - stop_abort = 1: from ACTIVE or GAP, enter DONE on the next edge.
  - stop_abort = 0: ACTIVE completes the current pattern and then enters DONE; GAP enters DONE on the next edge.
  - stop_req clears in DONE. A fall while in IDLE is ignored.
- Simultaneous events: end of the final burst coinciding with stop_req produces a single DONE (one done pulse).
- dac_data (registered, same cycle as pwm_out):
  - IDLE: idle_code
  - busy and bit = 1: level_hi
  - busy and bit = 0, including GAP and DONE: level_lo
- Counter widths: duty_cnt is DUTY_W, gap_cnt is GAP_W, burst_cnt is CNT_W, bit_idx is $clog2(PAT_WIDTH). Comparisons are unsigned with no wrap. In unlimited mode burst_cnt is not incremented.
- Shadow registers: inputs changing while busy have no effect until the next start.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package pattern_dac_pkg:
  - state encodings IDLE = 0, ACTIVE = 1, GAP = 2, DONE = 3 (3-bit)
  - RST_CODE default function
- Sub-module en_edge_det: registers pwm_en and outputs rise and fall. It is shared with other pattern blocks.

Test Plan:
- PAT=16'h000B, pat_len=3, duty=2, gap=4, pulse_num=2, hi=3FFF, lo=0000 -> pwm_out is 1,1,0,1 with 2 clks each; 4-clk gap; repeat once; done pulse; busy high for 8+4+8+1 = 21 clks.
- duty=0, gap=0, pat_len=0, PAT=1, pulse_num=3 -> dac_data is 3FFF for 3 consecutive clks, then DONE.
- pulse_num=0, abort=0, fall mid-pattern at bit 1 of 4 -> remaining bits complete, then done; no gap is emitted.
- pulse_num=0, abort=1, fall during GAP -> done on the next clk; dac_data = idle_code 2 clks after fall.
- pwm_en held high past DONE -> no restart; toggling pwm_en low then high -> new burst uses the values latched at that rising edge.
- rst_n asserted mid-ACTIVE -> dac_data = RST_CODE and busy = 0 immediately; after release with pwm_en high, no burst starts until a new rising edge.

Source files
------------

// File: rtl/pattern_dac_gen_pkg.sv
`default_nettype none
// ============================================================================
//  pattern_dac_pkg
//  Shared state encoding and reset-code helper for the pattern DAC blocks.
//  Revision: 1.0
// ============================================================================
package pattern_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_GAP    = 3'd2,
        ST_DONE   = 3'd3
    } state_e;

    // Mid-scale minus one: the DAC's quiet code for an offset-binary bus.
    function automatic int unsigned rst_code_default(input int unsigned dac_w);
        return (32'd1 << (dac_w - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_dac_gen_if.sv
`default_nettype none
// ============================================================================
//  pattern_dac_gen_if
//  Control/config inputs and DAC-side outputs of the pattern DAC generator.
//  Revision: 1.0
// ============================================================================
interface pattern_dac_gen_if #(
    parameter int PAT_WIDTH = 16,
    parameter int DAC_WIDTH = 14,
    parameter int DUTY_W    = 8,
    parameter int GAP_W     = 16,
    parameter int CNT_W     = 8
);
    localparam int IDX_W = $clog2(PAT_WIDTH);

    logic                 pwm_en;
    logic                 abort;
    logic [DUTY_W-1:0]    duty_num;
    logic [GAP_W-1:0]     gap_num;
    logic [CNT_W-1:0]     pulse_num;
    logic [PAT_WIDTH-1:0] pat;
    logic [IDX_W-1:0]     pat_len;
    logic [DAC_WIDTH-1:0] level_hi;
    logic [DAC_WIDTH-1:0] level_lo;
    logic [DAC_WIDTH-1:0] idle_code;
    logic [DAC_WIDTH-1:0] dac_data;
    logic                 pwm_out;
    logic                 busy;
    logic                 done;

    modport master (
        output pwm_en, abort, duty_num, gap_num, pulse_num, pat, pat_len,
               level_hi, level_lo, idle_code,
        input  dac_data, pwm_out, busy, done
    );

    modport slave (
        input  pwm_en, abort, duty_num, gap_num, pulse_num, pat, pat_len,
               level_hi, level_lo, idle_code,
        output dac_data, pwm_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pattern_dac_gen_en_edge_det.sv
`default_nettype none
// ============================================================================
//  en_edge_det
//  Registers an enable level and flags its rising and falling edges.
//  Revision: 1.0
// ============================================================================
module en_edge_det #(
    // Resetting to 1 means an enable already high at reset release is not an edge.
    parameter logic RST_VAL = 1'b1
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  en,
    output logic rise,
    output logic fall
);
    logic last_en_q;
    logic last_en_d;

    always_comb begin
        last_en_d = en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_en_q <= RST_VAL;
        end else begin
            last_en_q <= last_en_d;
        end
    end

    assign rise = en & ~last_en_q;
    assign fall = ~en & last_en_q;
endmodule
`default_nettype wire

// File: rtl/pattern_dac_gen.sv
`default_nettype none
// ============================================================================
//  pattern_dac_gen
//  Serialises a programmable bit pattern onto a DAC bus in repeated bursts.
//  Revision: 1.0
// ============================================================================
module pattern_dac_gen
    import pattern_dac_pkg::*;
#(
    parameter int PAT_WIDTH = 16,
    parameter int DAC_WIDTH = 14,
    parameter int DUTY_W    = 8,
    parameter int GAP_W     = 16,
    parameter int CNT_W     = 8,
    parameter logic [DAC_WIDTH-1:0] RST_CODE = DAC_WIDTH'(rst_code_default(DAC_WIDTH))
) (
    input  wire               clk,
    input  wire               rst_n,
    pattern_dac_gen_if.slave  bus
);
    localparam int IDX_W = $clog2(PAT_WIDTH);

    state_e               state_q, state_d;
    logic                 start_q, start_d;
    logic                 pwm_q, pwm_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DAC_WIDTH-1:0] dac_q, dac_d;
    logic [DUTY_W-1:0]    duty_cnt_q, duty_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_req_q, stop_req_d;
    logic                 stop_abort_q, stop_abort_d;
    logic [DUTY_W-1:0]    duty_sh_q, duty_sh_d;
    logic [GAP_W-1:0]     gap_sh_q, gap_sh_d;
    logic [CNT_W-1:0]     pulse_sh_q, pulse_sh_d;
    logic [PAT_WIDTH-1:0] pat_sh_q, pat_sh_d;
    logic [IDX_W-1:0]     len_sh_q, len_sh_d;
    logic [DAC_WIDTH-1:0] hi_sh_q, hi_sh_d;
    logic [DAC_WIDTH-1:0] lo_sh_q, lo_sh_d;

    logic rise, fall;
    logic bit_end, last_bit, gap_end, burst_hit, go_done;

    en_edge_det #(.RST_VAL(1'b1)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.pwm_en),
        .rise  (rise),
        .fall  (fall)
    );

    // A duty of 0 behaves as 1, so the terminal count is clamped at 0.
    assign bit_end   = (duty_cnt_q == ((duty_sh_q == '0) ? '0 : duty_sh_q - DUTY_W'(1)));
    assign last_bit  = (bit_idx_q == len_sh_q);
    assign gap_end   = (gap_cnt_q == gap_sh_q - GAP_W'(1));
    assign burst_hit = (pulse_sh_q != '0) &&
                       (({1'b0, burst_cnt_q} + (CNT_W+1)'(1)) == {1'b0, pulse_sh_q});

    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        pwm_d        = pwm_q;
        done_d       = 1'b0;
        duty_cnt_d   = duty_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_req_d   = stop_req_q;
        stop_abort_d = stop_abort_q;
        duty_sh_d    = duty_sh_q;
        gap_sh_d     = gap_sh_q;
        pulse_sh_d   = pulse_sh_q;
        pat_sh_d     = pat_sh_q;
        len_sh_d     = len_sh_q;
        hi_sh_d      = hi_sh_q;
        lo_sh_d      = lo_sh_q;
        go_done      = 1'b0;

        if (fall && (state_q == ST_ACTIVE || state_q == ST_GAP)) begin
            stop_req_d   = 1'b1;
            stop_abort_d = bus.abort;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d     = ST_ACTIVE;
                    bit_idx_d   = '0;
                    duty_cnt_d  = '0;
                    burst_cnt_d = '0;
                    pwm_d       = pat_sh_q[0];
                end else if (rise) begin
                    start_d    = 1'b1;
                    duty_sh_d  = bus.duty_num;
                    gap_sh_d   = bus.gap_num;
                    pulse_sh_d = bus.pulse_num;
                    pat_sh_d   = bus.pat;
                    len_sh_d   = bus.pat_len;
                    hi_sh_d    = bus.level_hi;
                    lo_sh_d    = bus.level_lo;
                end
            end
            ST_ACTIVE: begin
                if (stop_req_q && stop_abort_q) begin
                    go_done = 1'b1;
                end else if (!bit_end) begin
                    duty_cnt_d = duty_cnt_q + DUTY_W'(1);
                end else begin
                    duty_cnt_d = '0;
                    if (!last_bit) begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        pwm_d     = pat_sh_q[bit_idx_d];
                    end else if (burst_hit || stop_req_q) begin
                        go_done = 1'b1;
                    end else begin
                        if (pulse_sh_q != '0) begin
                            burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        end
                        bit_idx_d = '0;
                        if (gap_sh_q == '0) begin
                            pwm_d = pat_sh_q[0];
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                            pwm_d     = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (stop_req_q) begin
                    go_done = 1'b1;
                end else if (gap_end) begin
                    state_d    = ST_ACTIVE;
                    bit_idx_d  = '0;
                    duty_cnt_d = '0;
                    pwm_d      = pat_sh_q[0];
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                pwm_d      = 1'b0;
                stop_req_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                pwm_d   = 1'b0;
            end
        endcase

        // Final-burst end and a pending stop both land here: one DONE only.
        if (go_done) begin
            state_d    = ST_DONE;
            pwm_d      = 1'b0;
            done_d     = 1'b1;
            stop_req_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_IDLE) begin
            dac_d = bus.idle_code;
        end else begin
            dac_d = pwm_d ? hi_sh_q : lo_sh_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            pwm_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dac_q        <= RST_CODE;
            duty_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            bit_idx_q    <= '0;
            stop_req_q   <= 1'b0;
            stop_abort_q <= 1'b0;
            duty_sh_q    <= '0;
            gap_sh_q     <= '0;
            pulse_sh_q   <= '0;
            pat_sh_q     <= '0;
            len_sh_q     <= '0;
            hi_sh_q      <= '0;
            lo_sh_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            pwm_q        <= pwm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dac_q        <= dac_d;
            duty_cnt_q   <= duty_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_req_q   <= stop_req_d;
            stop_abort_q <= stop_abort_d;
            duty_sh_q    <= duty_sh_d;
            gap_sh_q     <= gap_sh_d;
            pulse_sh_q   <= pulse_sh_d;
            pat_sh_q     <= pat_sh_d;
            len_sh_q     <= len_sh_d;
            hi_sh_q      <= hi_sh_d;
            lo_sh_q      <= lo_sh_d;
        end
    end

    assign bus.dac_data = dac_q;
    assign bus.pwm_out  = pwm_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_pattern_dac_gen.sv
`default_nettype none
// ============================================================================
//  tb_pattern_dac_gen
//  Directed scoreboard bench: expected DAC samples are queued with their cycle.
//  Revision: 1.0
// ============================================================================
module tb_pattern_dac_gen;
    localparam logic [13:0] IDLE_C = 14'h2AAA;
    localparam logic [13:0] RST_C  = 14'h1FFF;

    typedef struct packed {
        logic [31:0] cyc;
        logic [13:0] dac;
        logic        pwm;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   exp_cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    pattern_dac_gen_if #(.PAT_WIDTH(16), .DAC_WIDTH(14), .DUTY_W(8), .GAP_W(16), .CNT_W(8)) bus ();

    pattern_dac_gen #(.PAT_WIDTH(16), .DAC_WIDTH(14), .DUTY_W(8), .GAP_W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every busy/done cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (bus.busy || bus.done)) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: cyc=%0d dac=%h pwm=%b done=%b, required no output",
                         cyc, bus.dac_data, bus.pwm_out, bus.done);
            end else begin
                mon_e = sb_q.pop_front();
                if (cyc == int'(mon_e.cyc) && bus.dac_data === mon_e.dac &&
                    bus.pwm_out === mon_e.pwm && bus.done === mon_e.done) begin
                    n_pass++;
                end else begin
                    $display("FAIL sb_sample: got cyc=%0d dac=%h pwm=%b done=%b, required cyc=%0d dac=%h pwm=%b done=%b",
                             cyc, bus.dac_data, bus.pwm_out, bus.done,
                             mon_e.cyc, mon_e.dac, mon_e.pwm, mon_e.done);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp_v);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [13:0] d, input logic p, input logic dn);
        exp_t t;
        t.cyc  = 32'(exp_cyc);
        t.dac  = d;
        t.pwm  = p;
        t.done = dn;
        sb_q.push_back(t);
        exp_cyc++;
    endtask

    task automatic push_pat(input logic [15:0] pt, input int len, input int duty,
                            input logic [13:0] hi, input logic [13:0] lo);
        int reps;
        reps = (duty == 0) ? 1 : duty;
        for (int i = 0; i <= len; i++)
            for (int k = 0; k < reps; k++)
                push(pt[i] ? hi : lo, pt[i], 1'b0);
    endtask

    task automatic push_gap(input int g, input logic [13:0] lo);
        for (int i = 0; i < g; i++) push(lo, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [15:0] pt, input logic [3:0] len, input logic [7:0] duty,
                       input logic [15:0] gap, input logic [7:0] pulses,
                       input logic [13:0] hi, input logic [13:0] lo);
        bus.pat = pt; bus.pat_len = len; bus.duty_num = duty; bus.gap_num = gap;
        bus.pulse_num = pulses; bus.level_hi = hi; bus.level_lo = lo;
    endtask

    // Rise is sampled at the next edge; first bit appears one edge later.
    task automatic start();
        bus.pwm_en = 1'b1;
        exp_cyc = cyc + 2;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.busy) && k < 100) begin
            tick(1);
            k++;
        end
        chk({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({nm, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pwm_en = 1'b0;
        bus.abort = 1'b0;
        bus.idle_code = IDLE_C;
        cfg(16'h0, 4'd0, 8'd0, 16'd0, 8'd0, 14'h0, 14'h0);
        tick(2);
        chk("rst_dac", 32'(bus.dac_data), 32'(RST_C));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pwm", 32'(bus.pwm_out), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_dac", 32'(bus.dac_data), 32'(IDLE_C));

        // Two finite bursts with a gap, then pwm_en stays high: no restart.
        cfg(16'h000B, 4'd3, 8'd2, 16'd4, 8'd2, 14'h3FFF, 14'h0000);
        start();
        push_pat(16'h000B, 3, 2, 14'h3FFF, 14'h0000);
        push_gap(4, 14'h0000);
        push_pat(16'h000B, 3, 2, 14'h3FFF, 14'h0000);
        push(14'h0000, 1'b0, 1'b1);
        drain("t1");
        tick(5);
        chk("t1_idle_hold", 32'(bus.dac_data), 32'(IDLE_C));

        // Back-to-back single-bit bursts; inputs scrambled after the latch.
        bus.pwm_en = 1'b0;
        tick(2);
        cfg(16'h0001, 4'd0, 8'd0, 16'd0, 8'd3, 14'h3FFF, 14'h0000);
        start();
        push(14'h3FFF, 1'b1, 1'b0);
        push(14'h3FFF, 1'b1, 1'b0);
        push(14'h3FFF, 1'b1, 1'b0);
        push(14'h0000, 1'b0, 1'b1);
        tick(1);
        cfg(16'h0000, 4'd3, 8'd5, 16'd7, 8'd0, 14'h1111, 14'h2222);
        drain("t2");

        // Unlimited, graceful stop during bit 1: pattern finishes, no gap.
        bus.pwm_en = 1'b0;
        bus.abort = 1'b0;
        tick(2);
        cfg(16'h0006, 4'd3, 8'd2, 16'd3, 8'd0, 14'h1234, 14'h0555);
        start();
        push_pat(16'h0006, 3, 2, 14'h1234, 14'h0555);
        push(14'h0555, 1'b0, 1'b1);
        tick(3);
        bus.pwm_en = 1'b0;
        drain("t3");

        // Unlimited, abort during the gap.
        bus.abort = 1'b1;
        tick(2);
        cfg(16'h0001, 4'd1, 8'd1, 16'd5, 8'd0, 14'h3FFF, 14'h0100);
        start();
        push_pat(16'h0001, 1, 1, 14'h3FFF, 14'h0100);
        push_gap(3, 14'h0100);
        push(14'h0100, 1'b0, 1'b1);
        tick(5);
        bus.pwm_en = 1'b0;
        tick(3);
        chk("t4_idle_after_fall", 32'(bus.dac_data), 32'(IDLE_C));
        drain("t4");

        // Asynchronous reset mid-ACTIVE, then pwm_en held high across release.
        bus.abort = 1'b0;
        tick(2);
        cfg(16'h000A, 4'd3, 8'd1, 16'd2, 8'd0, 14'h3FFF, 14'h0000);
        start();
        push(14'h0000, 1'b0, 1'b0);
        push(14'h3FFF, 1'b1, 1'b0);
        tick(4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_dac", 32'(bus.dac_data), 32'(RST_C));
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_pwm", 32'(bus.pwm_out), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("t5_no_restart_dac", 32'(bus.dac_data), 32'(IDLE_C));
        chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Final burst end coinciding with a graceful stop: exactly one done.
        bus.pwm_en = 1'b0;
        tick(2);
        cfg(16'h0005, 4'd2, 8'd1, 16'd2, 8'd1, 14'h0F0F, 14'h00F0);
        start();
        push_pat(16'h0005, 2, 1, 14'h0F0F, 14'h00F0);
        push(14'h00F0, 1'b0, 1'b1);
        tick(2);
        bus.pwm_en = 1'b0;
        drain("t6");
        tick(3);
        chk("t6_idle_dac", 32'(bus.dac_data), 32'(IDLE_C));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
